// File: rtl/mito_pkg.sv
// Shared layer-type and sequencer-state encodings plus buffer beat counts for MITO.
// Latency: none, this file holds types and constants only.
// Backpressure: not applicable.
package mito_pkg;

    typedef enum logic [1:0] {
        NONE          = 2'b00,
        CONVOLUTIONAL = 2'b01,
        FULLY         = 2'b10,
        POOLING       = 2'b11
    } layer_type_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_BIAS,
        LOAD_WGT,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    localparam int IFM_BEATS = 3;
    localparam int WGT_BEATS = 3;

endpackage

// File: rtl/seq_valid_pipe.sv
// In-flight tracker: PIPE_LAT-deep valid shift register following pixels through PE/ReLU/pool.
// Latency: out_vld exactly PIPE_LAT cycles after in_vld.
// Backpressure: none, the pipeline advances every cycle.
module seq_valid_pipe #(
    parameter int PIPE_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld,
    output logic empty
);

    localparam logic [PIPE_LAT-1:0] HEAD = PIPE_LAT'(1) << (PIPE_LAT - 1);

    logic [PIPE_LAT-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | PIPE_LAT'(in_vld);
        end
    end

    assign out_vld = sr[PIPE_LAT-1];

    // True once nothing remains behind the output stage, so the caller can
    // finish in the cycle right after the last out_vld.
    assign empty = !in_vld && ((sr & ~HEAD) == '0);

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: latches a descriptor on start, issues bias/weight/IFM strobes, tracks results to the OFM buffer.
// Latency: first strobe one cycle after start; ofm_valid PIPE_LAT cycles after each pixel's last IFM beat.
// Backpressure: none; build option MITO_SEQ_PERF_CNT_EN adds the busy-cycle counter on perf_cycles.
module layer_sequencer #(
    parameter int PIPE_LAT  = 4,
    parameter int PIX_CNT_W = 16,
    parameter int IFM_BEATS = mito_pkg::IFM_BEATS,
    parameter int WGT_BEATS = mito_pkg::WGT_BEATS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cfg_layer_type,
    input  logic [PIX_CNT_W-1:0] cfg_out_pixels,
    output logic [IFM_BEATS-1:0] ifm_read,
    output logic                 wgt_read,
    output logic                 bias_read,
    output logic [1:0]           mode,
    output logic                 ofm_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [31:0]          perf_cycles
);

    import mito_pkg::*;

    localparam int WCW = (WGT_BEATS > 1) ? $clog2(WGT_BEATS) : 1;

    seq_state_e           state;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic [WCW-1:0]       wgt_cnt;
    logic                 trk_empty;

    // Outputs are registered alongside the state so each strobe lines up with its state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            wgt_cnt   <= '0;
            mode      <= '0;
            ifm_read  <= '0;
            wgt_read  <= 1'b0;
            bias_read <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            ifm_read  <= '0;
            wgt_read  <= 1'b0;
            bias_read <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_layer_type == NONE) begin
                            cfg_err <= 1'b1;
                        end else begin
                            mode    <= cfg_layer_type;
                            pix_cnt <= cfg_out_pixels;
                            busy    <= 1'b1;
                            if (cfg_out_pixels == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else if (cfg_layer_type == POOLING) begin
                                state    <= STREAM;
                                ifm_read <= IFM_BEATS'(1);
                            end else begin
                                state     <= LOAD_BIAS;
                                bias_read <= 1'b1;
                            end
                        end
                    end
                end
                LOAD_BIAS: begin
                    state    <= LOAD_WGT;
                    wgt_read <= 1'b1;
                    wgt_cnt  <= WCW'(WGT_BEATS - 1);
                end
                LOAD_WGT: begin
                    if (wgt_cnt == '0) begin
                        state    <= STREAM;
                        ifm_read <= IFM_BEATS'(1);
                    end else begin
                        wgt_cnt  <= wgt_cnt - 1'b1;
                        wgt_read <= 1'b1;
                    end
                end
                STREAM: begin
                    // The top beat issues a pixel; the next pixel starts with no gap.
                    if (ifm_read[IFM_BEATS-1]) begin
                        pix_cnt <= pix_cnt - 1'b1;
                        if (pix_cnt == PIX_CNT_W'(1)) begin
                            state <= DRAIN;
                        end else begin
                            ifm_read <= IFM_BEATS'(1);
                        end
                    end else begin
                        ifm_read <= ifm_read << 1;
                    end
                end
                DRAIN: begin
                    if (trk_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (ifm_read[IFM_BEATS-1]),
        .out_vld (ofm_valid),
        .empty   (trk_empty)
    );

`ifdef MITO_SEQ_PERF_CNT_EN
    logic start_acc;
    assign start_acc = (state == IDLE) && start && (cfg_layer_type != NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed and random layers against a cycle-schedule model.
// Latency/backpressure: not applicable.
`timescale 1ns/1ps
module tb_layer_sequencer;

    localparam int PL = 4;
    localparam int WB = 3;
    localparam int EW = 43;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_layer_type = 2'b00;
    logic [15:0] cfg_out_pixels = 16'd0;
    logic [2:0]  ifm_read;
    logic        wgt_read;
    logic        bias_read;
    logic [1:0]  mode;
    logic        ofm_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [31:0] perf_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model state: current layer and what the outputs hold between layers.
    int m_type = 0;
    int m_n = 0;
    int m_t0 = 0;
    int m_done = 0;
    int m_prev_mode = 0;
    int m_prev_perf = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .PIPE_LAT  (PL),
        .PIX_CNT_W (16),
        .IFM_BEATS (3),
        .WGT_BEATS (WB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_layer_type (cfg_layer_type),
        .cfg_out_pixels (cfg_out_pixels),
        .ifm_read       (ifm_read),
        .wgt_read       (wgt_read),
        .bias_read      (bias_read),
        .mode           (mode),
        .ofm_valid      (ofm_valid),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .perf_cycles    (perf_cycles)
    );

    function automatic logic [EW-1:0] observed();
        return {ifm_read, wgt_read, bias_read, mode, ofm_valid, busy, done, cfg_err, perf_cycles};
    endfunction

    // Expected outputs in cycle k counted from the cycle start is presented.
    function automatic logic [EW-1:0] expect_at(input int k);
        logic [2:0]  ifm;
        logic        w, b, o, bz, d, e;
        logic [1:0]  m;
        logic [31:0] p;
        int          r;
        ifm = 3'b000;
        w = 1'b0; b = 1'b0; o = 1'b0; bz = 1'b0; d = 1'b0; e = 1'b0;
        m = 2'(m_prev_mode);
        p = 32'(m_prev_perf);
        if (k >= 1) begin
            if (m_type == 0) begin
                e = (k == 1);
            end else begin
                m  = 2'(m_type);
                bz = (k <= m_done);
                d  = (k == m_done);
                p  = (k - 1 < m_done) ? 32'(k - 1) : 32'(m_done);
                if (m_n != 0) begin
                    if (m_type != 3) begin
                        b = (k == 1);
                        w = (k >= 2) && (k <= 1 + WB);
                    end
                    if (k >= m_t0 && k < m_t0 + 3 * m_n)
                        ifm = 3'(1 << ((k - m_t0) % 3));
                    r = k - PL;
                    if (r >= m_t0 && r < m_t0 + 3 * m_n && ((r - m_t0) % 3) == 2)
                        o = 1'b1;
                end
            end
        end
`ifndef MITO_SEQ_PERF_CNT_EN
        p = 32'd0;
`endif
        return {ifm, w, b, m, o, bz, d, e, p};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] exp);
        logic [EW-1:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_layer(input int typ, input int n);
        m_type = typ;
        m_n    = n;
        m_t0   = (typ == 3) ? 1 : 2 + WB;
        m_done = (n == 0) ? 1 : m_t0 + 3 * n + PL;
    endtask

    // Runs one layer from cycle 0; glitch>0 pulses start with random cfg in that cycle.
    task automatic run_layer(input int typ, input int n, input int glitch, input int tail);
        int last;
        set_layer(typ, n);
        last = (typ == 0) ? 2 + tail : m_done + tail;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("type%0d_pix%0d_cyc%0d", typ, n, k), expect_at(k));
            if (k == 0) begin
                start          = 1'b1;
                cfg_layer_type = 2'(typ);
                cfg_out_pixels = 16'(n);
            end else begin
                start          = (k == glitch);
                cfg_layer_type = 2'($urandom);
                cfg_out_pixels = 16'($urandom_range(0, 20));
            end
        end
        start = 1'b0;
        if (typ != 0) begin
            m_prev_mode = typ;
            m_prev_perf = m_done;
        end
    endtask

    initial begin
        int typ, n, t0, d, g;

        repeat (3) @(negedge clk);
        check("reset_state", '0);
        rst_n = 1'b1;

        run_layer(1, 2, 6, 2);
        run_layer(3, 1, 8, 0);
        run_layer(1, 0, 1, 1);
        run_layer(0, 5, 0, 1);
        run_layer(2, 3, 4, 1);

        // Reset asserted mid-layer during cycle 9 of a conv layer.
        set_layer(1, 2);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("pre_rst_cyc%0d", k), expect_at(k));
            start          = (k == 0);
            cfg_layer_type = 2'b01;
            cfg_out_pixels = 16'd2;
        end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async", '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_prev_mode = 0;
        m_prev_perf = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_cyc%0d", k), '0);
        end
        run_layer(1, 2, 0, 1);

        for (int i = 0; i < 12; i++) begin
            typ = int'($urandom_range(0, 3));
            n   = int'($urandom_range(0, 5));
            t0  = (typ == 3) ? 1 : 2 + WB;
            d   = (n == 0) ? 1 : t0 + 3 * n + PL;
            g   = (typ == 0) ? 0 : int'($urandom_range(1, d));
            run_layer(typ, n, g, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one layer of work through the MITO accelerator datapath. On `start` it latches a layer descriptor, then issues bias, weight and IFM read strobes to the input buffers in a fixed order. It tracks every issued output pixel through the PE/ReLU/pooling pipeline and raises `ofm_valid` as each result reaches the OFM buffer. It sits between the host-facing start/config registers and the IFM/WGT/BIAS buffers, driving `mode` to the output mux.

## Interface
- `PIPE_LAT`, 4, cycles from final IFM beat of a pixel to its `ofm_valid`; legal range 1..15
- `PIX_CNT_W`, 16, width of output-pixel counter
- `IFM_BEATS`, 3, IFM read beats per pixel (`PE_ARR_SIZE/INPUT_IFM_REG`)
- `WGT_BEATS`, 3, weight read beats per layer (`PE_ARR_SIZE/INPUT_WGT_REG`)

Ports:
- `clk` in 1, single clock
- `rst_n` in 1, asynchronous, active-low reset
- `start` in 1, one-cycle request; sampled only in IDLE
- `cfg_layer_type` in 2, 01 CONVOLUTIONAL, 10 FULLY, 11 POOLING, 00 illegal
- `cfg_out_pixels` in PIX_CNT_W, output pixels in the layer
- `ifm_read` out 3, one-hot IFM beat select
- `wgt_read` out 1, weight buffer load strobe
- `bias_read` out 1, bias buffer load strobe
- `mode` out 2, latched layer type; drives output mux
- `ofm_valid` out 1, result present at OFM buffer input
- `busy` out 1, layer in progress
- `done` out 1, one-cycle pulse at layer completion
- `cfg_err` out 1, one-cycle pulse on `start` with type 00
- `perf_cycles` out 32, busy-cycle count (see Configuration)

## Operation
- States: IDLE, LOAD_BIAS, LOAD_WGT, STREAM, DRAIN, DONE.
- IDLE: on `start`, latch type and pixel count, and set `mode`. Type 00 leaves the FSM in IDLE and pulses `cfg_err`. A pixel count of 0 goes to DONE. POOLING goes to STREAM. Other types go to LOAD_BIAS.
- LOAD_BIAS: 1 cycle with `bias_read`=1, then LOAD_WGT.
- LOAD_WGT: WGT_BEATS cycles with `wgt_read`=1, then STREAM.
- STREAM: `ifm_read` cycles 001, 010, 100, one beat per cycle, with no gaps between pixels. The 100 beat issues a pixel. The last pixel's 100 beat goes to DRAIN.
- DRAIN: all read strobes 0. Wait until the in-flight tracker is empty, then DONE.
- DONE: one cycle with `done`=1, then IDLE.
- In-flight tracker: a PIPE_LAT-deep shift register. A 1 enters on each issue beat, and `ofm_valid` is its output.
- `start` outside IDLE is ignored. The latched config is immune to later `cfg_*` changes.
- The pixel counter counts down and never wraps. `mode` holds its value after DONE until the next accepted `start`.

## Timing
- Reset value of every output is 0, including `mode`=00 and `perf_cycles`=0. Reset asserted mid-layer clears the FSM, counter and tracker immediately; no strobe or `ofm_valid` may follow.
- `start` sampled in cycle 0. `busy` is 1 from cycle 1 through the DONE cycle inclusive.
- Conv/FC: `bias_read` in cycle 1, `wgt_read` in cycles 2..1+WGT_BEATS, first IFM beat in cycle 2+WGT_BEATS.
- Pooling: first IFM beat in cycle 1.
- `ofm_valid` is exactly PIPE_LAT cycles after each 100 beat. `done` is in the cycle after the final `ofm_valid`.
- A layer with 0 pixels: `done` in cycle 1, no strobes.
- `start` arriving in the DONE cycle is ignored. It is accepted in the next cycle (IDLE).

## Configuration
- `MITO_SEQ_PERF_CNT_EN` defined: `perf_cycles` increments every cycle `busy`=1, saturates at all-ones, and clears on accepted `start`.
- Not defined: `perf_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `mito_pkg`:
  - `layer_type_e` (NONE=00, CONVOLUTIONAL=01, FULLY=10, POOLING=11)
  - `seq_state_e`
  - constants `IFM_BEATS`, `WGT_BEATS`
- Sub-module `seq_valid_pipe`: parameterised PIPE_LAT shift register with `empty` flag, used as the in-flight tracker.

## Test plan
- Conv, 2 pixels, PIPE_LAT=4, start in cycle 0 -> `bias_read` in 1; `wgt_read` in 2–4; `ifm_read` 001/010/100 in 5–7 and 8–10; `ofm_valid` in 11 and 14; `done` in 15; `mode`=01.
- Pooling, 1 pixel -> no bias/weight strobes; beats in 1–3; `ofm_valid` in 7; `done` in 8; `mode`=11.
- `start` with type 00 -> `cfg_err` in cycle 1, `busy` stays 0, no strobes.
- Pixel count 0 with type 01 -> `done` in cycle 1, no strobes, `ofm_valid` never asserted.
- `rst_n` low during cycle 9 of the conv case -> all outputs 0 at once; no `ofm_valid` afterwards; new `start` runs normally.
- Second `start` pulsed in cycle 6 and `cfg_*` changed -> ignored, original layer completes unchanged. With the macro defined, `perf_cycles` = 15 after the first case.
